// File: rtl/param_display_pkg.sv
// param_display_pkg
// Shared types and constants for the FX parameter readout.
//   disp_state_t  : readout FSM states (IDLE, CONV, COMMIT)
//   BCD_DIGITS    : number of decimal digits produced per field
//   SEG_BLANK     : all segments off (active-low)
//   SEG7_TABLE    : active-low {g,f,e,d,c,b,a} codes for digits 0-9
//   seg7_encode() : digit to segment pattern, blank for anything above 9
package param_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } disp_state_t;

    localparam int BCD_DIGITS = 3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef logic [6:0] seg7_digit_t [10];

    localparam seg7_digit_t SEG7_TABLE = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000
    };

    // Non-decimal nibbles fall through to blank rather than indexing
    // past the end of the table.
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] code;
        code = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (digit == 4'(i)) begin
                code = SEG7_TABLE[i];
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_step.sv
// bin2bcd_step
// One combinational shift-add-3 (double-dabble) iteration.
//   din  : {bcd[4*BCD_DIGITS-1:0], bin[PARAM_W-1:0]} before the step
//   dout : the same register after add-3 correction and a left shift
module bin2bcd_step
    import param_display_pkg::*;
#(
    parameter int PARAM_W = 8
) (
    input  logic [4*BCD_DIGITS+PARAM_W-1:0] din,
    output logic [4*BCD_DIGITS+PARAM_W-1:0] dout
);

    logic [4*BCD_DIGITS+PARAM_W-1:0] adj;

    // Any BCD nibble of 5 or more would become 10+ after the shift, so
    // pre-add 3 to make it carry into the next decimal digit instead.
    always_comb begin
        adj = din;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (adj[PARAM_W + 4*i +: 4] >= 4'd5) begin
                adj[PARAM_W + 4*i +: 4] = adj[PARAM_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    assign dout = adj << 1;

endmodule

// File: rtl/param_display.sv
// param_display
// Readout for the FX parameter controller. Snapshots the selection and
// value whenever they change, converts each to decimal serially, then
// updates six active-low 7-segment digits in one go.
//   clk, reset     : system clock, synchronous active-high reset
//   fx_sel         : selected effect       -> hex5 (tens), hex4 (ones)
//   param_sel      : selected parameter    -> hex3
//   current_value  : parameter value       -> hex2..hex0
//   busy           : conversion in progress
//   disp_valid     : display holds a completed conversion
module param_display
    import param_display_pkg::*;
#(
    parameter int FX_COUNT    = 16,
    parameter int PARAM_COUNT = 8,
    parameter int PARAM_W     = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(FX_COUNT)-1:0]    fx_sel,
    input  logic [$clog2(PARAM_COUNT)-1:0] param_sel,
    input  logic [PARAM_W-1:0]             current_value,
    output logic [6:0]                     hex5,
    output logic [6:0]                     hex4,
    output logic [6:0]                     hex3,
    output logic [6:0]                     hex2,
    output logic [6:0]                     hex1,
    output logic [6:0]                     hex0,
    output logic                           busy,
    output logic                           disp_valid
);

    localparam int BCD_W = 4 * BCD_DIGITS;

    disp_state_t                    state;
    logic [$clog2(FX_COUNT)-1:0]    fx_snap;
    logic [$clog2(PARAM_COUNT)-1:0] param_snap;
    logic [PARAM_W-1:0]             value_snap;
    logic                           dirty;
    logic [1:0]                     field;
    logic [3:0]                     step;
    logic [BCD_W-1:0]               bcd_reg;
    logic [PARAM_W-1:0]             bin_reg;
    logic [BCD_W-1:0]               value_bcd;
    logic [7:0]                     fx_bcd;
    logic [3:0]                     param_bcd;

    logic [BCD_W+PARAM_W-1:0]       step_out;
    logic                           inputs_changed;

    bin2bcd_step #(.PARAM_W(PARAM_W)) u_step (
        .din  ({bcd_reg, bin_reg}),
        .dout (step_out)
    );

    assign inputs_changed = (fx_sel != fx_snap) || (param_sel != param_snap)
                         || (current_value != value_snap);

    // Readout FSM. The value is converted first, then fx, then param;
    // each field gets PARAM_W shift steps. Hex outputs only move in
    // COMMIT so the old digits stay up for the whole reconversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fx_snap    <= '0;
            param_snap <= '0;
            value_snap <= '0;
            dirty      <= 1'b1;
            field      <= '0;
            step       <= '0;
            bcd_reg    <= '0;
            bin_reg    <= '0;
            value_bcd  <= '0;
            fx_bcd     <= '0;
            param_bcd  <= '0;
            hex5       <= SEG_BLANK;
            hex4       <= SEG_BLANK;
            hex3       <= SEG_BLANK;
            hex2       <= SEG_BLANK;
            hex1       <= SEG_BLANK;
            hex0       <= SEG_BLANK;
            busy       <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dirty || inputs_changed) begin
                        fx_snap    <= fx_sel;
                        param_snap <= param_sel;
                        value_snap <= current_value;
                        dirty      <= 1'b0;
                        field      <= '0;
                        step       <= '0;
                        bcd_reg    <= '0;
                        bin_reg    <= current_value;
                        busy       <= 1'b1;
                        state      <= CONV;
                    end
                end

                CONV: begin
                    if (step == 4'(PARAM_W - 1)) begin
                        // Field done: park its digits and preload the next
                        // field's binary into the shifter.
                        step    <= '0;
                        bcd_reg <= '0;
                        field   <= field + 2'd1;
                        case (field)
                            2'd0: begin
                                value_bcd <= step_out[PARAM_W +: BCD_W];
                                bin_reg   <= PARAM_W'(fx_snap);
                            end
                            2'd1: begin
                                fx_bcd  <= step_out[PARAM_W +: 8];
                                bin_reg <= PARAM_W'(param_snap);
                            end
                            default: begin
                                param_bcd <= step_out[PARAM_W +: 4];
                                state     <= COMMIT;
                            end
                        endcase
                    end else begin
                        step    <= step + 4'd1;
                        bcd_reg <= step_out[PARAM_W +: BCD_W];
                        bin_reg <= step_out[PARAM_W-1:0];
                    end
                end

                COMMIT: begin
                    // Leading-zero suppression: value hundreds, value tens
                    // when hundreds is also zero, and fx tens.
                    hex5 <= (fx_bcd[7:4] == 4'd0) ? SEG_BLANK : seg7_encode(fx_bcd[7:4]);
                    hex4 <= seg7_encode(fx_bcd[3:0]);
                    hex3 <= seg7_encode(param_bcd);
                    hex2 <= (value_bcd[11:8] == 4'd0) ? SEG_BLANK
                                                      : seg7_encode(value_bcd[11:8]);
                    hex1 <= (value_bcd[11:4] == 8'd0) ? SEG_BLANK
                                                      : seg7_encode(value_bcd[7:4]);
                    hex0 <= seg7_encode(value_bcd[3:0]);
                    disp_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_display.sv
// tb_param_display
// Directed bench for param_display with the default parameters. All
// stimulus and sampling happen on the falling edge, so "cycle k" below
// means the k-th rising edge after the inputs were applied has passed.
module tb_param_display;

    localparam int FX_COUNT    = 16;
    localparam int PARAM_COUNT = 8;
    localparam int PARAM_W     = 8;

    localparam logic [6:0] BL = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] fx_sel = '0;
    logic [2:0] param_sel = '0;
    logic [7:0] current_value = '0;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic       busy, disp_valid;

    int checks = 0;
    int errors = 0;

    param_display #(
        .FX_COUNT    (FX_COUNT),
        .PARAM_COUNT (PARAM_COUNT),
        .PARAM_W     (PARAM_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fx_sel        (fx_sel),
        .param_sel     (param_sel),
        .current_value (current_value),
        .hex5          (hex5),
        .hex4          (hex4),
        .hex3          (hex3),
        .hex2          (hex2),
        .hex1          (hex1),
        .hex0          (hex0),
        .busy          (busy),
        .disp_valid    (disp_valid)
    );

    // 50 MHz system clock
    always #10 clk = ~clk;

    // Reference active-low segment patterns, written out independently
    function automatic logic [6:0] segOf(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BL;
        endcase
    endfunction

    // Single comparison point: counts every check, reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Compares all six digits against the expected patterns
    task automatic checkHex(input string tag, input logic [6:0] e5, input logic [6:0] e4,
                            input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
        checkOutput({tag, ".hex5"}, {25'd0, hex5}, {25'd0, e5});
        checkOutput({tag, ".hex4"}, {25'd0, hex4}, {25'd0, e4});
        checkOutput({tag, ".hex3"}, {25'd0, hex3}, {25'd0, e3});
        checkOutput({tag, ".hex2"}, {25'd0, hex2}, {25'd0, e2});
        checkOutput({tag, ".hex1"}, {25'd0, hex1}, {25'd0, e1});
        checkOutput({tag, ".hex0"}, {25'd0, hex0}, {25'd0, e0});
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a new input set on a falling edge
    task automatic applyStimulus(input logic [3:0] fx, input logic [2:0] prm,
                                 input logic [7:0] val);
        @(negedge clk);
        fx_sel        = fx;
        param_sel     = prm;
        current_value = val;
    endtask

    // Full conversion: applies inputs, waits the 26 edges to COMMIT, checks
    task automatic runAndCheck(input string tag, input logic [3:0] fx,
                               input logic [2:0] prm, input logic [7:0] val,
                               input logic [6:0] e5, input logic [6:0] e4,
                               input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
        applyStimulus(fx, prm, val);
        waitCycles(26);
        checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, ".valid"}, {31'd0, disp_valid}, 32'd1);
        checkHex(tag, e5, e4, e3, e2, e1, e0);
    endtask

    // Main directed sequence
    initial begin
        int sawBusy;
        int sawChange;
        int rises;
        logic prevBusy;

        // Reset state, then fx=3 param=2 value=128 straight out of reset
        fx_sel = 4'd3; param_sel = 3'd2; current_value = 8'd128;
        reset = 1'b1;
        waitCycles(3);
        checkOutput("rst.busy", {31'd0, busy}, 32'd0);
        checkOutput("rst.valid", {31'd0, disp_valid}, 32'd0);
        checkHex("rst", BL, BL, BL, BL, BL, BL);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("c0.busy", {31'd0, busy}, 32'd1);
        checkHex("c0", BL, BL, BL, BL, BL, BL);
        waitCycles(12);
        checkOutput("c12.busy", {31'd0, busy}, 32'd1);
        waitCycles(12);
        checkOutput("c24.busy", {31'd0, busy}, 32'd1);
        checkOutput("c24.valid", {31'd0, disp_valid}, 32'd0);
        checkHex("c24", BL, BL, BL, BL, BL, BL);
        waitCycles(1);
        checkOutput("c25.busy", {31'd0, busy}, 32'd0);
        checkOutput("c25.valid", {31'd0, disp_valid}, 32'd1);
        checkHex("c25", BL, segOf(3), segOf(2), segOf(1), segOf(2), segOf(8));

        // Leading-zero blanking and multi-digit values
        runAndCheck("zero", 4'd0, 3'd0, 8'd0, BL, segOf(0), segOf(0), BL, BL, segOf(0));
        runAndCheck("max", 4'd15, 3'd7, 8'd255,
                    segOf(1), segOf(5), segOf(7), segOf(2), segOf(5), segOf(5));
        runAndCheck("v9", 4'd15, 3'd7, 8'd9,
                    segOf(1), segOf(5), segOf(7), BL, BL, segOf(9));
        runAndCheck("v100", 4'd15, 3'd7, 8'd100,
                    segOf(1), segOf(5), segOf(7), segOf(1), segOf(0), segOf(0));

        // Value changes mid-conversion: old snapshot commits, then a rerun
        applyStimulus(4'd15, 3'd7, 8'd10);
        waitCycles(6);
        current_value = 8'd11;
        waitCycles(20);
        checkOutput("mid1.busy", {31'd0, busy}, 32'd0);
        checkHex("mid1", segOf(1), segOf(5), segOf(7), BL, segOf(1), segOf(0));
        waitCycles(1);
        checkOutput("mid2.busy", {31'd0, busy}, 32'd1);
        checkOutput("mid2.valid", {31'd0, disp_valid}, 32'd1);
        checkOutput("mid2.hex0", {25'd0, hex0}, {25'd0, segOf(0)});
        waitCycles(24);
        checkOutput("mid3.hex0", {25'd0, hex0}, {25'd0, segOf(0)});
        waitCycles(1);
        checkOutput("mid4.busy", {31'd0, busy}, 32'd0);
        checkHex("mid4", segOf(1), segOf(5), segOf(7), BL, segOf(1), segOf(1));

        // Reset partway through a conversion
        applyStimulus(4'd7, 3'd2, 8'd42);
        waitCycles(13);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("abort.busy", {31'd0, busy}, 32'd0);
        checkOutput("abort.valid", {31'd0, disp_valid}, 32'd0);
        checkHex("abort", BL, BL, BL, BL, BL, BL);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("restart.busy", {31'd0, busy}, 32'd1);
        waitCycles(25);
        checkOutput("restart.valid", {31'd0, disp_valid}, 32'd1);
        checkHex("restart", BL, segOf(7), segOf(2), BL, segOf(4), segOf(2));

        // Stable inputs: no activity and a frozen display
        sawBusy = 0;
        sawChange = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy) sawBusy++;
            if ({hex5, hex4, hex3, hex2, hex1, hex0} !==
                {BL, segOf(7), segOf(2), BL, segOf(4), segOf(2)}) sawChange++;
        end
        checkOutput("stable.busy", sawBusy, 0);
        checkOutput("stable.hex", sawChange, 0);

        // Only param_sel changes: exactly one conversion, only hex3 moves
        applyStimulus(4'd7, 3'd5, 8'd42);
        rises = 0;
        prevBusy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy && !prevBusy) rises++;
            prevBusy = busy;
        end
        checkOutput("p5.convs", rises, 1);
        checkOutput("p5.busy", {31'd0, busy}, 32'd0);
        checkHex("p5", BL, segOf(7), segOf(5), BL, segOf(4), segOf(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
